// File: rtl/wb_scoreboard_pkg.sv
// rtl/wb_scoreboard_pkg.sv - shared register-index types and scoreboard sizing
package wb_scoreboard_pkg;

   localparam int NUM_REGS     = 16;
   localparam int IDX_W        = $clog2(NUM_REGS);
   localparam int SB_CNT_W     = 2;
   localparam int DRAIN_CYCLES = 3;
   localparam int DRAIN_W      = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

   typedef logic [IDX_W-1:0] reg_idx_t;

   typedef enum logic {
      SB_RUN   = 1'b0,
      SB_DRAIN = 1'b1
   } sb_state_t;

endpackage

// File: rtl/wb_scoreboard_sb_counter.sv
// rtl/wb_scoreboard_sb_counter.sv - per-register in-flight write counter
module sb_counter #(
   parameter int W = 2
) (
   input  logic clk,
   input  logic rst_async_n,
   input  logic inc_i,
   input  logic dec_i,
   input  logic clr_i,
   output logic sat_o,
   output logic zero_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   assign sat_o  = (cnt_q == {W{1'b1}});
   assign zero_o = (cnt_q == '0);

   // Overflow/underflow are refused here so a misbehaving caller cannot wrap the count.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && !dec_i && !sat_o) begin
         cnt_d = cnt_q + 1'b1;
      end else if (dec_i && !inc_i && !zero_o) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_async_n) begin
      if (!rst_async_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/wb_scoreboard.sv
// rtl/wb_scoreboard.sv - in-flight write scoreboard gating issue on RAW/saturation hazards
module wb_scoreboard
   import wb_scoreboard_pkg::*;
(
   input  logic                clk,
   input  logic                rst_async_n,
   input  logic                issue_valid,
   input  logic                issue_use_rs1,
   input  logic [IDX_W-1:0]    issue_rs1,
   input  logic                issue_use_rs2,
   input  logic [IDX_W-1:0]    issue_rs2,
   input  logic                issue_wr_rd,
   input  logic [IDX_W-1:0]    issue_rd,
   output logic                issue_ready,
   input  logic                wb_write_en,
   input  logic [IDX_W-1:0]    wb_write_index,
   input  logic                wb_write_pc_en,
   output logic [NUM_REGS-1:0] pending,
   output logic                draining,
   output logic [15:0]         stall_cycles,
   output logic                underflow_err
);

   sb_state_t          state_q;
   logic [DRAIN_W-1:0] drain_q;
   logic [15:0]        stall_q, stall_d;
   logic               underflow_q, underflow_d;

   logic [NUM_REGS-1:0] zero_vec, sat_vec, inc_vec, dec_vec;
   logic                redirect, accept, retire, same_reg_pair;
   logic                rs1_busy, rs2_busy, rd_full;

   for (genvar i = 0; i < NUM_REGS; i++) begin : g_cnt
      sb_counter #(.W(SB_CNT_W)) u_cnt (
         .clk         (clk),
         .rst_async_n (rst_async_n),
         .inc_i       (inc_vec[i]),
         .dec_i       (dec_vec[i]),
         .clr_i       (redirect),
         .sat_o       (sat_vec[i]),
         .zero_o      (zero_vec[i])
      );
   end

   // Hazards look only at registered counts: a retire this cycle does not unblock issue until next.
   always_comb begin
      rs1_busy    = issue_use_rs1 && !zero_vec[issue_rs1];
      rs2_busy    = issue_use_rs2 && !zero_vec[issue_rs2];
      rd_full     = issue_wr_rd && sat_vec[issue_rd];
      issue_ready = (state_q == SB_RUN) && !rs1_busy && !rs2_busy && !rd_full;
   end

   always_comb begin
      inc_vec       = '0;
      dec_vec       = '0;
      redirect      = (state_q == SB_RUN) && wb_write_pc_en;
      accept        = issue_valid && issue_ready && issue_wr_rd && !redirect;
      retire        = (state_q == SB_RUN) && wb_write_en && !wb_write_pc_en;
      same_reg_pair = accept && retire && (issue_rd == wb_write_index);
      if (accept && !same_reg_pair) inc_vec[issue_rd] = 1'b1;
      if (retire && !same_reg_pair) dec_vec[wb_write_index] = 1'b1;

      underflow_d = underflow_q;
      if (retire && !same_reg_pair && zero_vec[wb_write_index]) underflow_d = 1'b1;

      stall_d = stall_q;
      if (issue_valid && !issue_ready && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_async_n) begin
      if (!rst_async_n) begin
         state_q     <= SB_RUN;
         drain_q     <= '0;
         stall_q     <= '0;
         underflow_q <= 1'b0;
      end else begin
         stall_q     <= stall_d;
         underflow_q <= underflow_d;
         case (state_q)
            SB_RUN: begin
               if (wb_write_pc_en) begin
                  state_q <= SB_DRAIN;
                  drain_q <= DRAIN_W'(DRAIN_CYCLES - 1);
               end
            end
            SB_DRAIN: begin
               if (drain_q == '0) begin
                  state_q <= SB_RUN;
               end else begin
                  drain_q <= drain_q - 1'b1;
               end
            end
            default: state_q <= SB_RUN;
         endcase
      end
   end

   assign pending       = ~zero_vec;
   assign draining      = (state_q == SB_DRAIN);
   assign stall_cycles  = stall_q;
   assign underflow_err = underflow_q;

endmodule
